logic_bist: RTL

Built-in self-test initiator for the 4-bit bitwise logic units (NOR/AND/OR/XOR) in the ALU. It drives every operand pair {a,b} into an external logic unit and captures the unit's result. It compares each result against an internally computed expected value, then reports pass/fail, the error count and the first failing vector. It is the hardware initiator and checker for the logic-unit responders, and replaces exhaustive simulation-only sweeps.

---
 rtl/logic_bist_pkg.sv | 32 +++
 rtl/bist_delay_line.sv | 43 ++++
 rtl/logic_bist.sv | 121 ++++++++++++
 3 files changed

// File: rtl/logic_bist_pkg.sv
// Shared types and the reference model for the logic-unit BIST.
package logic_bist_pkg;

    localparam int EXP_W = 32;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Callers zero-extend operands and truncate the result to their width.
    function automatic logic [EXP_W-1:0] expected(input op_e f,
                                                  input logic [EXP_W-1:0] a,
                                                  input logic [EXP_W-1:0] b);
        case (f)
            OP_NOR:  expected = ~(a | b);
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            default: expected = a ^ b;
        endcase
    endfunction

endpackage

// File: rtl/bist_delay_line.sv
// Aligns presented vectors with the unit's registered latency; depth 0 is a wire.
module bist_delay_line #(
    parameter int DEPTH = 0,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_rst;
            assign o_valid = i_valid;
            assign o_data  = i_data;
        end else begin : g_shift
            logic [DEPTH-1:0]         r_vld;
            logic [DEPTH-1:0][DW-1:0] r_dat;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_vld <= '0;
                    r_dat <= '0;
                end else begin
                    r_vld[0] <= i_valid;
                    r_dat[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end

            assign o_valid = r_vld[DEPTH-1];
            assign o_data  = r_dat[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/logic_bist.sv
// Exhaustive operand sweep and checker for a bitwise logic unit.
module logic_bist
    import logic_bist_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 2*WIDTH+1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [WIDTH-1:0] y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_y
);

    localparam int VW  = 2*WIDTH;
    localparam int DCW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    state_e           r_state, w_state_nxt;
    op_e              r_op;
    logic [VW-1:0]    r_vec;
    logic [DCW-1:0]   r_drain;
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] w_err_nxt;
    logic             w_sweep_start;
    logic             w_dly_vld;
    logic [VW-1:0]    w_dly_dat;
    logic [WIDTH-1:0] w_dly_a, w_dly_b, w_exp;
    logic             w_mis;

    assign {a_o, b_o} = (r_state == IDLE) ? '0 : r_vec;
    assign busy       = (r_state == RUN) || (r_state == DRAIN);
    assign done       = (r_state == DONE);
    assign err_cnt    = r_err;

    assign w_sweep_start = start && ((r_state == IDLE) || (r_state == DONE));

    bist_delay_line #(.DEPTH(DUT_LAT), .DW(VW)) u_dly (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_valid (r_state == RUN),
        .i_data  ({a_o, b_o}),
        .o_valid (w_dly_vld),
        .o_data  (w_dly_dat)
    );

    assign w_dly_a = w_dly_dat[VW-1:WIDTH];
    assign w_dly_b = w_dly_dat[WIDTH-1:0];
    assign w_exp   = WIDTH'(expected(r_op, EXP_W'(w_dly_a), EXP_W'(w_dly_b)));
    assign w_mis   = w_dly_vld && (y_i != w_exp);

    always_comb begin
        w_err_nxt = r_err;
        if (w_mis && (r_err != '1))
            w_err_nxt = r_err + 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_nxt = RUN;
            RUN:        if (r_vec == '1) w_state_nxt = (DUT_LAT > 0) ? DRAIN : DONE;
            DRAIN:      if (r_drain == DCW'(DUT_LAT-1)) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= OP_NOR;
            r_vec   <= '0;
            r_drain <= '0;
            r_err   <= '0;
            fail_a  <= '0;
            fail_b  <= '0;
            fail_y  <= '0;
            pass    <= 1'b0;
        end else if (w_sweep_start) begin
            r_op    <= op_e'(op);
            r_vec   <= '0;
            r_drain <= '0;
            r_err   <= '0;
            fail_a  <= '0;
            fail_b  <= '0;
            fail_y  <= '0;
            pass    <= 1'b0;
        end else begin
            // vec parks on the last vector so DRAIN keeps presenting it
            if ((r_state == RUN) && (r_vec != '1))
                r_vec <= r_vec + 1'b1;
            if (r_state == DRAIN)
                r_drain <= r_drain + 1'b1;
            if (w_mis) begin
                r_err <= w_err_nxt;
                if (r_err == '0) begin
                    fail_a <= w_dly_a;
                    fail_b <= w_dly_b;
                    fail_y <= y_i;
                end
            end
            // the final compare lands on the same edge that enters DONE
            if ((w_state_nxt == DONE) && (r_state != DONE))
                pass <= (w_err_nxt == '0);
        end
    end

endmodule
